// File: rtl/alu_top.sv
// Registered ALU execute stage with four units (arith, logic, compare, shift), one enabled per cycle by ALU_FUN[3:2].
// Latency: one clk edge from operand/opcode sampling to result and flag; async active-high rst clears everything at once.
// Backpressure: none, a new opcode is accepted every cycle. Define ALU_SIGNED_CMP_EN for two's-complement greater/less.
module alu_top #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [width-1:0] Arith_OUT,
    output logic             Carry_OUT,
    output logic             Arith_Flag,
    output logic [width-1:0] Logic_OUT,
    output logic             Logic_Flag,
    output logic [width-1:0] CMP_OUT,
    output logic             CMP_Flag,
    output logic [width-1:0] Shift_OUT,
    output logic             Shift_Flag
);

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_e;

    localparam logic [width-1:0] CMP_EQ_CODE = width'(1);
    localparam logic [width-1:0] CMP_GT_CODE = width'(2);
    localparam logic [width-1:0] CMP_LT_CODE = width'(3);

    unit_e            unit_sel;
    logic [1:0]       op_sel;

    logic [width:0]     sum;
    logic [width-1:0]   diff;
    logic [2*width-1:0] prod;
    logic [width-1:0]   quot;
    logic               div_by_zero;
    logic               a_gt_b;
    logic               a_lt_b;

    logic [width-1:0] arith_out_d, arith_out_q;
    logic             carry_out_d, carry_out_q;
    logic             arith_flag_d, arith_flag_q;
    logic [width-1:0] logic_out_d, logic_out_q;
    logic             logic_flag_d, logic_flag_q;
    logic [width-1:0] cmp_out_d, cmp_out_q;
    logic             cmp_flag_d, cmp_flag_q;
    logic [width-1:0] shift_out_d, shift_out_q;
    logic             shift_flag_d, shift_flag_q;

    assign unit_sel = unit_e'(ALU_FUN[3:2]);
    assign op_sel   = ALU_FUN[1:0];

    always_comb begin
        sum         = {1'b0, A} + {1'b0, B};
        diff        = A - B;
        prod        = {{width{1'b0}}, A} * {{width{1'b0}}, B};
        div_by_zero = (B == '0);
        quot        = div_by_zero ? '1 : (A / B);
`ifdef ALU_SIGNED_CMP_EN
        a_gt_b      = $signed(A) > $signed(B);
        a_lt_b      = $signed(A) < $signed(B);
`else
        a_gt_b      = A > B;
        a_lt_b      = A < B;
`endif
    end

    // Every unit defaults to cleared so a non-selected unit zeroes its bus and flag on the same edge.
    always_comb begin
        arith_out_d  = '0;
        carry_out_d  = 1'b0;
        arith_flag_d = 1'b0;
        logic_out_d  = '0;
        logic_flag_d = 1'b0;
        cmp_out_d    = '0;
        cmp_flag_d   = 1'b0;
        shift_out_d  = '0;
        shift_flag_d = 1'b0;

        case (unit_sel)
            UNIT_ARITH: begin
                arith_flag_d = 1'b1;
                case (op_sel)
                    2'b00: begin
                        arith_out_d = sum[width-1:0];
                        carry_out_d = sum[width];
                    end
                    2'b01: begin
                        arith_out_d = diff;
                        carry_out_d = (A < B);
                    end
                    2'b10: begin
                        arith_out_d = prod[width-1:0];
                        carry_out_d = |prod[2*width-1:width];
                    end
                    default: begin
                        arith_out_d = quot;
                        carry_out_d = div_by_zero;
                    end
                endcase
            end
            UNIT_LOGIC: begin
                logic_flag_d = 1'b1;
                case (op_sel)
                    2'b00:   logic_out_d = A & B;
                    2'b01:   logic_out_d = A | B;
                    2'b10:   logic_out_d = ~(A & B);
                    default: logic_out_d = ~(A | B);
                endcase
            end
            UNIT_CMP: begin
                cmp_flag_d = 1'b1;
                case (op_sel)
                    2'b00:   cmp_out_d = '0;
                    2'b01:   cmp_out_d = (A == B) ? CMP_EQ_CODE : '0;
                    2'b10:   cmp_out_d = a_gt_b   ? CMP_GT_CODE : '0;
                    default: cmp_out_d = a_lt_b   ? CMP_LT_CODE : '0;
                endcase
            end
            default: begin
                shift_flag_d = 1'b1;
                case (op_sel)
                    2'b00:   shift_out_d = {1'b0, A[width-1:1]};
                    2'b01:   shift_out_d = {A[width-2:0], 1'b0};
                    2'b10:   shift_out_d = {1'b0, B[width-1:1]};
                    default: shift_out_d = {B[width-2:0], 1'b0};
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arith_out_q  <= '0;
            carry_out_q  <= 1'b0;
            arith_flag_q <= 1'b0;
            logic_out_q  <= '0;
            logic_flag_q <= 1'b0;
            cmp_out_q    <= '0;
            cmp_flag_q   <= 1'b0;
            shift_out_q  <= '0;
            shift_flag_q <= 1'b0;
        end else begin
            arith_out_q  <= arith_out_d;
            carry_out_q  <= carry_out_d;
            arith_flag_q <= arith_flag_d;
            logic_out_q  <= logic_out_d;
            logic_flag_q <= logic_flag_d;
            cmp_out_q    <= cmp_out_d;
            cmp_flag_q   <= cmp_flag_d;
            shift_out_q  <= shift_out_d;
            shift_flag_q <= shift_flag_d;
        end
    end

    assign Arith_OUT  = arith_out_q;
    assign Carry_OUT  = carry_out_q;
    assign Arith_Flag = arith_flag_q;
    assign Logic_OUT  = logic_out_q;
    assign Logic_Flag = logic_flag_q;
    assign CMP_OUT    = cmp_out_q;
    assign CMP_Flag   = cmp_flag_q;
    assign Shift_OUT  = shift_out_q;
    assign Shift_Flag = shift_flag_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top: table of hand-computed results plus reset sequences.
module tb_alu_top;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic [15:0] Arith_OUT;
    logic        Carry_OUT;
    logic        Arith_Flag;
    logic [15:0] Logic_OUT;
    logic        Logic_Flag;
    logic [15:0] CMP_OUT;
    logic        CMP_Flag;
    logic [15:0] Shift_OUT;
    logic        Shift_Flag;

    int errors = 0;
    int checks = 0;

    alu_top #(.width(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [15:0] arith;
        logic        carry;
        logic [15:0] lgc;
        logic [15:0] cmp;
        logic [15:0] shf;
        logic [3:0]  flags;  // {arith, logic, cmp, shift}
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("Arith_OUT", idx, Arith_OUT, v.arith);
        check("Carry_OUT", idx, {15'd0, Carry_OUT}, {15'd0, v.carry});
        check("Logic_OUT", idx, Logic_OUT, v.lgc);
        check("CMP_OUT",   idx, CMP_OUT,   v.cmp);
        check("Shift_OUT", idx, Shift_OUT, v.shf);
        check("flags",     idx, {12'd0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}, {12'd0, v.flags});
    endtask

    task automatic check_zero(input int idx);
        vec_t z;
        z = '0;
        check_all(idx, z);
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_FUN = fun;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        A       = 16'h1234;
        B       = 16'hABCD;
        ALU_FUN = 4'b0010;

        //        a        b        fun      arith    c     logic    cmp      shift    flags
        vq.push_back({16'd5, 16'd2, 4'b0000, 16'd7,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd5, 16'd2, 4'b0001, 16'd3,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd5, 16'd2, 4'b0010, 16'd10,     1'b0, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd5, 16'd2, 4'b0011, 16'd2,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd5, 16'd2, 4'b0100, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b0100});
        vq.push_back({16'd5, 16'd2, 4'b0101, 16'd0,      1'b0, 16'h0007, 16'd0, 16'd0, 4'b0100});
        vq.push_back({16'd5, 16'd2, 4'b0110, 16'd0,      1'b0, 16'hFFFF, 16'd0, 16'd0, 4'b0100});
        vq.push_back({16'd5, 16'd2, 4'b0111, 16'd0,      1'b0, 16'hFFF8, 16'd0, 16'd0, 4'b0100});
        vq.push_back({16'd5, 16'd2, 4'b1000, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b0010});
        vq.push_back({16'd5, 16'd2, 4'b1001, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b0010});
        vq.push_back({16'd5, 16'd2, 4'b1010, 16'd0,      1'b0, 16'h0000, 16'd2, 16'd0, 4'b0010});
        vq.push_back({16'd5, 16'd2, 4'b1011, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd0, 4'b0010});
        vq.push_back({16'd9, 16'd9, 4'b1001, 16'd0,      1'b0, 16'h0000, 16'd1, 16'd0, 4'b0010});
        vq.push_back({16'd1, 16'd4, 4'b1011, 16'd0,      1'b0, 16'h0000, 16'd3, 16'd0, 4'b0010});
        vq.push_back({16'd5, 16'd2, 4'b1100, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd2,  4'b0001});
        vq.push_back({16'd5, 16'd2, 4'b1101, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd10, 4'b0001});
        vq.push_back({16'd5, 16'd2, 4'b1110, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd1,  4'b0001});
        vq.push_back({16'd5, 16'd2, 4'b1111, 16'd0,      1'b0, 16'h0000, 16'd0, 16'd4,  4'b0001});
        vq.push_back({16'hFFFF, 16'd1, 4'b0000, 16'd0,   1'b1, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd0, 16'd1, 4'b0001, 16'hFFFF,   1'b1, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd7, 16'd0, 4'b0011, 16'hFFFF,   1'b1, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'h0100, 16'h0100, 4'b0010, 16'd0, 1'b1, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'h0100, 16'h0101, 4'b0010, 16'h0100, 1'b1, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'd100, 16'd7, 4'b0011, 16'd14,   1'b0, 16'h0000, 16'd0, 16'd0, 4'b1000});
        vq.push_back({16'h8001, 16'h8000, 4'b1101, 16'd0, 1'b0, 16'h0000, 16'd0, 16'h0002, 4'b0001});
        vq.push_back({16'h8001, 16'h8000, 4'b1110, 16'd0, 1'b0, 16'h0000, 16'd0, 16'h4000, 4'b0001});
`ifdef ALU_SIGNED_CMP_EN
        vq.push_back({16'hFFFF, 16'd1, 4'b1010, 16'd0,   1'b0, 16'h0000, 16'd0, 16'd0, 4'b0010});
        vq.push_back({16'hFFFF, 16'd1, 4'b1011, 16'd0,   1'b0, 16'h0000, 16'd3, 16'd0, 4'b0010});
`else
        vq.push_back({16'hFFFF, 16'd1, 4'b1010, 16'd0,   1'b0, 16'h0000, 16'd2, 16'd0, 4'b0010});
        vq.push_back({16'hFFFF, 16'd1, 4'b1011, 16'd0,   1'b0, 16'h0000, 16'd0, 16'd0, 4'b0010});
`endif

        // Reset held from time 0, sampled before the first rising edge.
        #2;
        check_zero(-1);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].a, vq[i].b, vq[i].fun);
            check_all(i, vq[i]);
        end

        // Reset pulse between two ops: clears mid-cycle without an edge, next op is correct.
        apply(16'd5, 16'd2, 4'b0000);
        check("pre_rst Arith_OUT", 100, Arith_OUT, 16'd7);
        rst = 1'b1;
        #1;
        check_zero(101);
        @(negedge clk);
        A       = 16'd5;
        B       = 16'd2;
        ALU_FUN = 4'b0110;
        #1;
        check_zero(102);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst Logic_OUT", 103, Logic_OUT, 16'hFFFF);
        check("post_rst flags", 103, {12'd0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}, 16'h0004);
        check("post_rst Arith_OUT", 103, Arith_OUT, 16'd0);

        // Reset asserted across a clock edge keeps outputs cleared.
        rst = 1'b1;
        A       = 16'hFFFF;
        B       = 16'd1;
        ALU_FUN = 4'b0000;
        @(posedge clk);
        #1;
        check_zero(104);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release Arith_OUT", 105, Arith_OUT, 16'd0);
        check("rst_release Carry_OUT", 105, {15'd0, Carry_OUT}, 16'd1);
        check("rst_release flags", 105, {12'd0, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}, 16'h0008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
